// File: rtl/ads_spi_master.sv
// ads_spi_master: Avalon-MM front end for the ADS7843 touch controller.
// A command byte written to address 0 launches one 24-DCLK chip-select frame.
// The 12-bit conversion result is captured from DCLK rises 10..21.
// Optional build macro: ADS_SPI_IRQ_EN adds a transfer-done interrupt and its
// enable bit. With the macro undefined, irq is tied low and the enable bit reads 0.
module ads_spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    output logic        ads_cs_n,
    output logic        ads_dclk,
    output logic        ads_din,
    input  logic        ads_dout
);

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [4:0] LAST_BIT  = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [4:0]  r_bit;
    logic [6:0]  r_cmd;
    logic [23:0] r_shift;
    logic [11:0] r_result;
    logic        r_busy;
    logic        r_done;
    logic        r_collision;
    logic [15:0] r_readdata;
    logic        r_cs_n;
    logic        r_dclk;
    logic        r_din;

    state_t      w_state_next;
    logic [7:0]  w_cnt_next;
    logic [4:0]  w_bit_next;
    logic        w_cs_n_next;
    logic        w_dclk_next;
    logic        w_din_next;
    logic        w_sample;
    logic        w_finish;
    logic        w_cnt_last;
    logic        w_wr0;
    logic        w_wr1;
    logic        w_rd0;
    logic        w_start;
    logic        w_collide;
    logic        w_irq_en_bit;
    logic [15:0] w_status;
    logic        w_unused;

    assign w_wr0      = chipselect && write && (address == 2'd0);
    assign w_wr1      = chipselect && write && (address == 2'd1);
    assign w_rd0      = chipselect && read  && (address == 2'd0);
    assign w_start    = w_wr0 && !r_busy;
    assign w_collide  = w_wr0 && r_busy;
    assign w_cnt_last = (r_cnt == DIV_LAST);
    assign w_status   = {12'b0, w_irq_en_bit, r_collision, r_done, r_busy};
    assign w_unused   = &{1'b0, writedata[15:8], r_shift[23]};

    assign readdata = r_readdata;
    assign ads_cs_n = r_cs_n;
    assign ads_dclk = r_dclk;
    assign ads_din  = r_din;

    // Next-state logic: frame sequencing and the next values of the pin flops.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_cs_n_next  = r_cs_n;
        w_dclk_next  = r_dclk;
        w_din_next   = r_din;
        w_sample     = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_SETUP;
                    w_cnt_next   = 8'd0;
                    w_bit_next   = 5'd0;
                    w_cs_n_next  = 1'b0;
                    w_dclk_next  = 1'b0;
                    w_din_next   = writedata[7];
                end
            end
            ST_SETUP: begin
                if (w_cnt_last) begin
                    // First DCLK rise; the ADS data line is sampled here.
                    w_state_next = ST_SHIFT;
                    w_cnt_next   = 8'd0;
                    w_dclk_next  = 1'b1;
                    w_sample     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            ST_SHIFT: begin
                if (w_cnt_last) begin
                    w_cnt_next = 8'd0;
                    if (r_dclk) begin
                        // Falling edge: present the next command bit, zeros after bit 8.
                        w_dclk_next = 1'b0;
                        w_din_next  = (r_bit < 5'd7) ? r_cmd[3'd6 - r_bit[2:0]] : 1'b0;
                    end else if (r_bit == LAST_BIT) begin
                        w_state_next = ST_HOLD;
                    end else begin
                        w_bit_next  = r_bit + 5'd1;
                        w_dclk_next = 1'b1;
                        w_sample    = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            ST_HOLD: begin
                if (w_cnt_last) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = 8'd0;
                    w_cs_n_next  = 1'b1;
                    w_finish     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cs_n_next  = 1'b1;
                w_dclk_next  = 1'b0;
            end
        endcase
    end

    // State register plus the flops that drive the ADS pins directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_bit   <= 5'd0;
            r_cs_n  <= 1'b1;
            r_dclk  <= 1'b0;
            r_din   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_cs_n  <= w_cs_n_next;
            r_dclk  <= w_dclk_next;
            r_din   <= w_din_next;
        end
    end

    // Command latch, per-rise sample shifter and result capture at frame end.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd    <= 7'd0;
            r_shift  <= 24'd0;
            r_result <= 12'd0;
        end else begin
            if (w_start) begin
                r_cmd <= writedata[6:0];
            end
            if (w_sample) begin
                r_shift <= {r_shift[22:0], ads_dout};
            end
            // After 24 rises, rise k sits at bit 24-k: rises 10..21 are bits 14..3.
            if (w_finish) begin
                r_result <= r_shift[14:3];
            end
        end
    end

    // Status flags: busy, done (set beats read-clear), sticky collision (set beats clear).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            if (w_start) begin
                r_busy <= 1'b1;
            end else if (w_finish) begin
                r_busy <= 1'b0;
            end
            if (w_finish) begin
                r_done <= 1'b1;
            end else if (w_start || w_rd0) begin
                r_done <= 1'b0;
            end
            if (w_collide) begin
                r_collision <= 1'b1;
            end else if (w_wr1 && writedata[2]) begin
                r_collision <= 1'b0;
            end
        end
    end

    // Registered read data, one cycle after the read strobe is sampled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 16'd0;
        end else if (chipselect && read) begin
            case (address)
                2'd0:    r_readdata <= {4'b0, r_result};
                2'd1:    r_readdata <= w_status;
                default: r_readdata <= 16'd0;
            endcase
        end
    end

`ifdef ADS_SPI_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    assign w_irq_en_bit = r_irq_en;
    assign irq          = r_irq;

    // Interrupt enable and the registered done-and-enabled interrupt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr1) begin
                r_irq_en <= writedata[3];
            end
            r_irq <= r_done && r_irq_en;
        end
    end
`else
    assign w_irq_en_bit = 1'b0;
    assign irq          = 1'b0;
`endif

endmodule

// File: tb/tb_ads_spi_master.sv
// Bench for ads_spi_master: table of directed frames, hand-written corner
// sequences and randomized frames against a behavioural ADS7843 model.
`timescale 1ns/1ps
module tb_ads_spi_master;

    localparam int DIV   = 4;
    localparam int FRAME = 50 * DIV;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [15:0] writedata = 16'd0;
    logic [15:0] readdata;
    logic        irq;
    logic        ads_cs_n;
    logic        ads_dclk;
    logic        ads_din;
    logic        ads_dout = 1'b0;

    int n_vec  = 0;
    int n_miss = 0;

    ads_spi_master #(.CLK_DIV(DIV)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .ads_cs_n   (ads_cs_n),
        .ads_dclk   (ads_dclk),
        .ads_din    (ads_din),
        .ads_dout   (ads_dout)
    );

    always #5 clk = ~clk;

    // ---------------- ADS7843 behavioural model ----------------
    // Bit for DCLK rise k is pattern[k]; it is presented before the rise and
    // held until the following DCLK fall.
    logic [24:1] next_bits = '0;
    logic [24:1] cur_bits  = '0;
    logic        din_log [1:24];
    int          rise_cnt  = 0;
    int          low_cnt   = 0;
    int          frame_len = 0;
    int          first_gap = 0;

    initial begin
        logic prev_cs;
        logic prev_dclk;
        prev_cs   = 1'b1;
        prev_dclk = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_cs === 1'b1 && ads_cs_n === 1'b0) begin
                cur_bits = next_bits;
                rise_cnt = 0;
                low_cnt  = 0;
                for (int i = 1; i <= 24; i++) din_log[i] = 1'bx;
                ads_dout = next_bits[1];
            end
            if (ads_cs_n === 1'b0) low_cnt++;
            if (prev_cs === 1'b0 && ads_cs_n === 1'b1) frame_len = low_cnt;
            if (prev_dclk === 1'b0 && ads_dclk === 1'b1 && ads_cs_n === 1'b0) begin
                rise_cnt++;
                if (rise_cnt <= 24) din_log[rise_cnt] = ads_din;
                if (rise_cnt == 1) first_gap = low_cnt - 1;
            end
            if (prev_dclk === 1'b1 && ads_dclk === 1'b0 && ads_cs_n === 1'b0 && rise_cnt < 24)
                ads_dout = cur_bits[rise_cnt + 1];
            prev_cs   = ads_cs_n;
            prev_dclk = ads_dclk;
        end
    end

    function automatic logic [24:1] make_pattern(input logic [7:0] junk, input logic busy_bit,
                                                 input logic [11:0] data, input logic [2:0] tail);
        logic [24:1] p;
        p = '0;
        for (int i = 1; i <= 8; i++) p[i] = junk[8 - i];
        p[9] = busy_bit;
        for (int i = 0; i < 12; i++) p[10 + i] = data[11 - i];
        for (int i = 0; i < 3; i++) p[22 + i] = tail[2 - i];
        return p;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; writedata = 16'd0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic wait_frame_end(input string name);
        int k;
        k = 0;
        while (ads_cs_n !== 1'b1 && k < 4 * FRAME) begin
            @(negedge clk);
            k++;
        end
        check({name, " frame end"}, ads_cs_n, 1);
    endtask

    task automatic check_frame_shape(input string name, input logic [7:0] cmd);
        logic [7:0] got;
        int nz;
        got = 8'd0;
        nz  = 0;
        for (int i = 1; i <= 8; i++) got = {got[6:0], din_log[i]};
        for (int i = 9; i <= 24; i++) if (din_log[i] !== 1'b0) nz++;
        check({name, " cs low cycles"}, frame_len, FRAME);
        check({name, " dclk rises"}, rise_cnt, 24);
        check({name, " first rise gap"}, first_gap, DIV);
        check({name, " din cmd"}, got, cmd);
        check({name, " din tail zeros"}, nz, 0);
    endtask

    task automatic run_frame(input string name, input logic [7:0] cmd,
                             input logic [24:1] pat, input logic [15:0] exp_rd);
        logic [15:0] rd;
        next_bits = pat;
        bus_write(2'd0, {8'h00, cmd});
        check({name, " start cs_n"}, ads_cs_n, 0);
        wait_frame_end(name);
        @(negedge clk);
        check_frame_shape(name, cmd);
        bus_read(2'd1, rd); check({name, " status done"}, rd, 16'h0002);
        bus_read(2'd0, rd); check({name, " result"}, rd, exp_rd);
        $display("frame %s cmd=0x%02h result=0x%04h expected=0x%04h", name, cmd, rd, exp_rd);
        bus_read(2'd1, rd); check({name, " status cleared"}, rd, 16'h0000);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  junk;
        logic        busy_bit;
        logic [11:0] data;
        logic [2:0]  tail;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic [7:0]  rc;
        logic [11:0] rdata;
        int k;

        vecs[0] = '{8'h90, 8'h00, 1'b0, 12'hABC, 3'b000, 16'h0ABC};
        vecs[1] = '{8'hD0, 8'hFF, 1'b1, 12'hFFF, 3'b111, 16'h0FFF};
        vecs[2] = '{8'h93, 8'hFF, 1'b1, 12'h000, 3'b111, 16'h0000};
        vecs[3] = '{8'hFF, 8'h5A, 1'b0, 12'h800, 3'b101, 16'h0800};
        vecs[4] = '{8'h01, 8'hA5, 1'b1, 12'h001, 3'b010, 16'h0001};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset cs_n", ads_cs_n, 1);
        check("reset dclk", ads_dclk, 0);
        check("reset din", ads_din, 0);
        check("reset irq", irq, 0);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            check($sformatf("reset read addr%0d", a), rd, 16'h0000);
        end
        bus_write(2'd2, 16'hFFFF);
        bus_read(2'd2, rd); check("addr2 write ignored", rd, 16'h0000);
        check("addr2 write no start", ads_cs_n, 1);

        // Table-driven frames
        for (int i = 0; i < 5; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].cmd,
                      make_pattern(vecs[i].junk, vecs[i].busy_bit, vecs[i].data, vecs[i].tail),
                      vecs[i].exp_rd);

        // Collision while busy, then collision clear
        next_bits = make_pattern(8'h00, 1'b0, 12'h123, 3'b000);
        bus_write(2'd0, 16'h0090);
        repeat (8) @(negedge clk);
        bus_write(2'd0, 16'h00D0);
        bus_read(2'd1, rd); check("collision status busy", rd, 16'h0005);
        wait_frame_end("collision");
        @(negedge clk);
        check_frame_shape("collision", 8'h90);
        bus_read(2'd1, rd); check("collision status done", rd, 16'h0006);
        bus_write(2'd1, 16'h0004);
        bus_read(2'd1, rd); check("collision cleared", rd, 16'h0002);
        bus_read(2'd0, rd); check("collision result", rd, 16'h0123);
        $display("frame collision cmd=0x90 result=0x%04h expected=0x0123", rd);

        // Read of address 0 in the same cycle done is set: done must survive
        next_bits = make_pattern(8'h00, 1'b0, 12'h456, 3'b000);
        bus_write(2'd0, 16'h0090);
        repeat (FRAME - 1) @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = 2'd0;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        check("race cs_n high at done", ads_cs_n, 1);
        check("race read old result", readdata, 16'h0123);
        bus_read(2'd1, rd); check("race done kept", rd, 16'h0002);
        bus_read(2'd0, rd); check("race new result", rd, 16'h0456);
        $display("frame race cmd=0x90 result=0x%04h expected=0x0456", rd);

        // Interrupt
`ifdef ADS_SPI_IRQ_EN
        bus_write(2'd1, 16'h0008);
        bus_read(2'd1, rd); check("irq_en status", rd, 16'h0008);
        next_bits = make_pattern(8'h00, 1'b0, 12'h5A5, 3'b000);
        bus_write(2'd0, 16'h0090);
        wait_frame_end("irq");
        check("irq at done edge", irq, 0);
        @(negedge clk);
        check("irq after done", irq, 1);
        bus_read(2'd0, rd); check("irq result", rd, 16'h05A5);
        check("irq held after read", irq, 1);
        @(negedge clk);
        check("irq cleared by read", irq, 0);
        bus_write(2'd1, 16'h0000);
`else
        bus_write(2'd1, 16'h0008);
        bus_read(2'd1, rd); check("irq_en absent status", rd, 16'h0000);
        next_bits = make_pattern(8'h00, 1'b0, 12'h5A5, 3'b000);
        bus_write(2'd0, 16'h0090);
        wait_frame_end("irq");
        repeat (2) @(negedge clk);
        check("irq tied low", irq, 0);
        bus_read(2'd1, rd); check("irq absent done status", rd, 16'h0002);
        bus_read(2'd0, rd); check("irq result", rd, 16'h05A5);
`endif
        $display("frame irq cmd=0x90 result=0x%04h expected=0x05A5", rd);

        // Back-to-back frames
        next_bits = make_pattern(8'h00, 1'b1, 12'h3C5, 3'b011);
        bus_write(2'd0, 16'h0090);
        @(negedge clk);
        next_bits = make_pattern(8'hFF, 1'b0, 12'hA5A, 3'b100);
        wait_frame_end("b2b first");
        chipselect = 1'b1; write = 1'b1; address = 2'd0; writedata = 16'h00D0;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; writedata = 16'd0;
        check("b2b second accepted", ads_cs_n, 0);
        bus_read(2'd1, rd); check("b2b status busy no collision", rd, 16'h0001);
        bus_read(2'd0, rd); check("b2b first result", rd, 16'h03C5);
        $display("frame b2b1 cmd=0x90 result=0x%04h expected=0x03C5", rd);
        wait_frame_end("b2b second");
        @(negedge clk);
        check_frame_shape("b2b second", 8'hD0);
        bus_read(2'd1, rd); check("b2b status done", rd, 16'h0002);
        bus_read(2'd0, rd); check("b2b second result", rd, 16'h0A5A);
        $display("frame b2b2 cmd=0xd0 result=0x%04h expected=0x0A5A", rd);

        // Randomized frames
        for (int i = 0; i < 8; i++) begin
            rc    = 8'($urandom_range(0, 255));
            rdata = 12'($urandom_range(0, 4095));
            run_frame($sformatf("rand%0d", i), rc,
                      make_pattern(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                                   rdata, 3'($urandom_range(0, 7))),
                      {4'b0, rdata});
        end

        // Make sure a nonzero result is held before the mid-frame reset
        run_frame("pre-reset", 8'h90, make_pattern(8'h00, 1'b0, 12'hF0F, 3'b000), 16'h0F0F);

        // Reset mid-frame at DCLK rise 12
        next_bits = make_pattern(8'h00, 1'b0, 12'h777, 3'b000);
        bus_write(2'd0, 16'h0090);
        k = 0;
        while (rise_cnt != 12 && k < 4 * FRAME) begin
            @(negedge clk);
            k++;
        end
        check("reached rise 12", rise_cnt, 12);
        reset_n = 1'b0;
        #1;
        check("mid reset cs_n", ads_cs_n, 1);
        check("mid reset dclk", ads_dclk, 0);
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd1, rd); check("mid reset status", rd, 16'h0000);
        bus_read(2'd0, rd); check("mid reset result cleared", rd, 16'h0000);
        run_frame("post-reset", 8'hD0, make_pattern(8'h00, 1'b0, 12'h9E1, 3'b000), 16'h09E1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
